// File: rtl/cmos_gen_pkg.sv
// Shared types and constants for the CMOS sensor stream generator.
// Holds the frame-phase state enum, pattern mode codes and the constants
// for the optional pixel-noise LFSR (enabled by CMOS_GEN_NOISE_EN).
package cmos_gen_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBACK,
      ACTIVE,
      VFRONT
   } state_e;

   localparam logic [1:0] MODE_HRAMP = 2'd0;
   localparam logic [1:0] MODE_VRAMP = 2'd1;
   localparam logic [1:0] MODE_CHECK = 2'd2;
   localparam logic [1:0] MODE_FCNT  = 2'd3;

   // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1: taps at bits 15,13,12,10.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] i_state);
      return {i_state[14:0], ^(i_state & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/cmos_gen_pattern.sv
// Combinational test-pattern generator: maps the latched mode, pixel
// coordinates and completed-frame count to one 8-bit gray pixel.
module cmos_gen_pattern
   import cmos_gen_pkg::*;
#(
   parameter int CHK_SHIFT = 3
) (
   input  logic [1:0]  i_mode,
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   input  logic [15:0] i_frame_cnt,
   output logic [7:0]  o_pix
);

   logic [15:0] w_xs;
   logic [15:0] w_ys;
   logic        w_chk;

   // Checkerboard square index: parity of the scaled x and y coordinates.
   assign w_xs  = i_x >> CHK_SHIFT;
   assign w_ys  = i_y >> CHK_SHIFT;
   assign w_chk = w_xs[0] ^ w_ys[0];

   // Only the low byte of each coordinate and the square parity are needed.
   logic w_unused_bits;
   assign w_unused_bits = ^{w_xs[15:1], w_ys[15:1], i_x[15:8], i_y[15:8], i_frame_cnt[15:8]};

   // Pixel value selection per pattern mode.
   always_comb begin
      // NOTE: default assigned first so every path drives o_pix and no latch is inferred.
      o_pix = 8'h00;
      case (i_mode)
         MODE_HRAMP: o_pix = i_x[7:0];
         MODE_VRAMP: o_pix = i_y[7:0];
         MODE_CHECK: o_pix = w_chk ? 8'hFF : 8'h00;
         MODE_FCNT:  o_pix = i_frame_cnt[7:0];
         default:    o_pix = 8'h00;
      endcase
   end

endmodule

// File: rtl/cmos_stream_gen.sv
// CMOS sensor stream transmitter: frame FSM, h/v counters, registered
// vsync/href/data outputs and frame accounting. One pixel per clk_cmos.
// Optional feature macro: CMOS_GEN_NOISE_EN adds LFSR noise on data[1:0].
module cmos_stream_gen
   import cmos_gen_pkg::*;
#(
   parameter int H_ACTIVE  = 1280,
   parameter int H_BLANK   = 244,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 8,
   parameter int V_ACTIVE  = 1024,
   parameter int V_FRONT   = 4,
   parameter int CHK_SHIFT = 3
) (
   input  logic        clk_cmos,
   input  logic        rst_n,
   input  logic        gen_en,
   input  logic [1:0]  gen_mode,
   output logic        cmos_vsync,
   output logic        cmos_href,
   output logic [7:0]  cmos_data,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;

   // Timing must fit the 16-bit counters; sync and active phases are mandatory.
   if (H_ACTIVE < 1 || H_BLANK < 1 || H_TOTAL > 65535) begin : g_bad_h
      $error("cmos_stream_gen: horizontal timing out of range");
   end
   if (V_SYNC < 1 || V_SYNC > 65535 || V_ACTIVE < 1 || V_ACTIVE > 65535) begin : g_bad_v
      $error("cmos_stream_gen: V_SYNC/V_ACTIVE out of range");
   end
   if (V_BACK < 0 || V_BACK > 65535 || V_FRONT < 0 || V_FRONT > 65535) begin : g_bad_porch
      $error("cmos_stream_gen: V_BACK/V_FRONT out of range");
   end

   localparam logic [15:0] LP_H_LAST  = 16'(H_TOTAL - 1);
   localparam logic [15:0] LP_H_ACT   = 16'(H_ACTIVE);
   localparam logic [15:0] LP_VS_LAST = 16'(V_SYNC - 1);
   localparam logic [15:0] LP_VB_LAST = 16'(V_BACK - 1);
   localparam logic [15:0] LP_VA_LAST = 16'(V_ACTIVE - 1);
   localparam logic [15:0] LP_VF_LAST = 16'(V_FRONT - 1);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [15:0] r_h;
   logic [15:0] r_v;
   logic [15:0] w_h_nxt;
   logic [15:0] w_v_nxt;
   logic [15:0] w_v_last;
   logic [1:0]  r_mode;
   logic        w_latch;
   logic        w_href;
   logic        w_last;
   logic [7:0]  w_pix;
   logic [7:0]  w_pix_out;

   logic        r_vsync;
   logic        r_href;
   logic [7:0]  r_data;
   logic        r_frame_done;
   logic [15:0] r_frame_cnt;

   // Last line index of the current phase.
   always_comb begin
      w_v_last = 16'h0000;
      case (r_state)
         VSYNC:   w_v_last = LP_VS_LAST;
         VBACK:   w_v_last = LP_VB_LAST;
         ACTIVE:  w_v_last = LP_VA_LAST;
         VFRONT:  w_v_last = LP_VF_LAST;
         default: w_v_last = 16'h0000;
      endcase
   end

   // Next state and counters; zero-length porches are skipped at the phase boundary.
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h + 16'd1;
      w_v_nxt     = r_v;
      if (r_state == IDLE) begin
         w_h_nxt = 16'h0000;
         w_v_nxt = 16'h0000;
         if (gen_en) begin
            w_state_nxt = VSYNC;
         end
      end else if (r_h == LP_H_LAST) begin
         w_h_nxt = 16'h0000;
         if (r_v == w_v_last) begin
            w_v_nxt = 16'h0000;
            case (r_state)
               VSYNC: begin
                  if (V_BACK > 0) w_state_nxt = VBACK;
                  else            w_state_nxt = ACTIVE;
               end
               VBACK: w_state_nxt = ACTIVE;
               ACTIVE: begin
                  if (V_FRONT > 0)  w_state_nxt = VFRONT;
                  else if (gen_en)  w_state_nxt = VSYNC;
                  else              w_state_nxt = IDLE;
               end
               VFRONT: begin
                  if (gen_en) w_state_nxt = VSYNC;
                  else        w_state_nxt = IDLE;
               end
               default: w_state_nxt = IDLE;
            endcase
         end else begin
            w_v_nxt = r_v + 16'd1;
         end
      end
   end

   // Mode is captured only when a new frame begins, so mid-frame changes are ignored.
   assign w_latch = (w_state_nxt == VSYNC) && (r_state != VSYNC);

   assign w_href = (r_state == ACTIVE) && (r_h < LP_H_ACT);
   assign w_last = (r_state == ACTIVE) && (r_v == LP_VA_LAST) && (r_h == LP_H_ACT);

   cmos_gen_pattern #(
      .CHK_SHIFT (CHK_SHIFT)
   ) u_pattern (
      .i_mode      (r_mode),
      .i_x         (r_h),
      .i_y         (r_v),
      .i_frame_cnt (r_frame_cnt),
      .o_pix       (w_pix)
   );

`ifdef CMOS_GEN_NOISE_EN
   logic [15:0] r_lfsr;

   // Noise source steps once per emitted active pixel.
   always_ff @(posedge clk_cmos) begin
      if (!rst_n) begin
         r_lfsr <= LFSR_SEED;
      end else if (w_href) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign w_pix_out = w_pix ^ {6'b000000, r_lfsr[1:0]};
`else
   assign w_pix_out = w_pix;
`endif

   // FSM state, counters and latched pattern mode.
   always_ff @(posedge clk_cmos) begin
      // NOTE: reset is sampled on the clock edge (synchronous); a mid-frame reset aborts at once.
      if (!rst_n) begin
         r_state <= IDLE;
         r_h     <= 16'h0000;
         r_v     <= 16'h0000;
         r_mode  <= MODE_HRAMP;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state <= w_state_nxt;
         r_h     <= w_h_nxt;
         r_v     <= w_v_nxt;
         if (w_latch) begin
            r_mode <= gen_mode;
         end
      end
   end

   // Registered outputs, one cycle behind the counters.
   always_ff @(posedge clk_cmos) begin
      if (!rst_n) begin
         r_vsync      <= 1'b0;
         r_href       <= 1'b0;
         r_data       <= 8'h00;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= 16'h0000;
      end else begin
         r_vsync      <= (r_state == VSYNC);
         r_href       <= w_href;
         r_data       <= w_href ? w_pix_out : 8'h00;
         r_frame_done <= w_last;
         if (w_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign cmos_vsync = r_vsync;
   assign cmos_href  = r_href;
   assign cmos_data  = r_data;
   assign frame_done = r_frame_done;
   assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_cmos_stream_gen.sv
// Self-checking bench for cmos_stream_gen using a frame-offset reference model:
// each frame is a fixed-length window of cycles from its start edge, and the
// expected outputs are derived from the offset into that window.
module tb_cmos_stream_gen;

   localparam int HA = 8;
   localparam int HB = 4;
   localparam int VS = 1;
   localparam int VB = 2;
   localparam int VA = 4;
   localparam int VF = 1;
   localparam int CS = 1;
   localparam int HT = HA + HB;
   localparam int FRAME = HT * (VS + VB + VA + VF);
   localparam int DONE_OFS = (VS + VB + VA - 1) * HT + HA;
   localparam int FIRST_HREF = 1 + (VS + VB) * HT;

`ifdef CMOS_GEN_NOISE_EN
   localparam logic [7:0] DATA_MASK = 8'hFC;
`else
   localparam logic [7:0] DATA_MASK = 8'hFF;
`endif

   logic        clk_cmos = 1'b0;
   logic        rst_n    = 1'b0;
   logic        gen_en   = 1'b0;
   logic [1:0]  gen_mode = 2'd0;
   logic        cmos_vsync;
   logic        cmos_href;
   logic [7:0]  cmos_data;
   logic        frame_done;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int e = 0;

   // Reference model state.
   bit          m_busy = 1'b0;
   int          m_s    = 0;
   logic [1:0]  m_mode = 2'd0;
   logic [15:0] m_cnt  = 16'h0000;
   logic        x_vs, x_hr, x_fd;
   logic [7:0]  x_d;

   cmos_stream_gen #(
      .H_ACTIVE  (HA),
      .H_BLANK   (HB),
      .V_SYNC    (VS),
      .V_BACK    (VB),
      .V_ACTIVE  (VA),
      .V_FRONT   (VF),
      .CHK_SHIFT (CS)
   ) dut (
      .clk_cmos   (clk_cmos),
      .rst_n      (rst_n),
      .gen_en     (gen_en),
      .gen_mode   (gen_mode),
      .cmos_vsync (cmos_vsync),
      .cmos_href  (cmos_href),
      .cmos_data  (cmos_data),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk_cmos = ~clk_cmos;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   function automatic logic [7:0] ref_pix(input logic [1:0] mode, input int x, input int y,
                                          input logic [15:0] cnt);
      case (mode)
         2'd0:    return 8'(x);
         2'd1:    return 8'(y);
         2'd2:    return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 8'hFF : 8'h00;
         default: return cnt[7:0];
      endcase
   endfunction

   // Advance the model by one rising edge using the inputs sampled at that edge.
   task automatic model_edge();
      int o, ln, c;
      x_vs = 1'b0;
      x_hr = 1'b0;
      x_d  = 8'h00;
      x_fd = 1'b0;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_cnt  = 16'h0000;
      end else begin
         if (m_busy) begin
            o = e - m_s - 1;
            if (o >= 0 && o < FRAME) begin
               ln = o / HT;
               c  = o % HT;
               x_vs = (ln < VS);
               if (ln >= VS + VB && ln < VS + VB + VA && c < HA) begin
                  x_hr = 1'b1;
                  x_d  = ref_pix(m_mode, c, ln - VS - VB, m_cnt);
               end
               if (o == DONE_OFS) begin
                  x_fd  = 1'b1;
                  m_cnt = m_cnt + 16'd1;
               end
            end
         end
         if (!m_busy || (e - m_s) == FRAME) begin
            if (gen_en) begin
               m_busy = 1'b1;
               m_s    = e;
               m_mode = gen_mode;
            end else begin
               m_busy = 1'b0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk_cmos);
      e++;
      model_edge();
      #1;
      check("vsync", {31'd0, cmos_vsync}, {31'd0, x_vs});
      check("href", {31'd0, cmos_href}, {31'd0, x_hr});
      check("data", {24'd0, cmos_data & DATA_MASK}, {24'd0, x_d & DATA_MASK});
      check("frame_done", {31'd0, frame_done}, {31'd0, x_fd});
      check("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int e0, first_vs, first_hr, vs_seen, fd_n, last_fd, bad_int;

      // Reset state, then a mode-0 frame with gen_en dropped during ACTIVE.
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(2);
      gen_mode = 2'd0;
      gen_en   = 1'b1;
      e0 = e + 1;
      first_vs = -1;
      first_hr = -1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (first_vs < 0 && cmos_vsync) first_vs = e - e0;
         if (first_hr < 0 && cmos_href)  first_hr = e - e0;
         if (e - e0 == 50) gen_en = 1'b0;
      end
      check("first_vsync_ofs", first_vs, 1);
      check("first_href_ofs", first_hr, FIRST_HREF);
      vs_seen = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (cmos_vsync) vs_seen++;
      end
      check("idle_vsync_count", vs_seen, 0);
      check("cnt_after_drop", {16'd0, frame_cnt}, 1);

      // Checkerboard, single frame.
      gen_mode = 2'd2;
      gen_en   = 1'b1;
      step();
      gen_en = 1'b0;
      run(FRAME + 10);

      // Continuous frame-count pattern from a fresh reset: three frames.
      rst_n = 1'b0;
      step();
      rst_n    = 1'b1;
      gen_mode = 2'd3;
      gen_en   = 1'b1;
      fd_n = 0;
      last_fd = -1;
      bad_int = 0;
      for (int i = 0; i < 3 * FRAME + 5; i++) begin
         if (i == 3 * FRAME - 10) gen_en = 1'b0;
         step();
         if (frame_done) begin
            if (last_fd >= 0 && (e - last_fd) != FRAME) bad_int++;
            last_fd = e;
            fd_n++;
         end
      end
      check("done_pulses", fd_n, 3);
      check("done_interval_bad", bad_int, 0);
      check("cnt_after_three", {16'd0, frame_cnt}, 3);

      // Mode change mid-frame takes effect on the next frame only.
      gen_mode = 2'd0;
      gen_en   = 1'b1;
      step();
      run(20);
      gen_mode = 2'd1;
      run(150);
      gen_en = 1'b0;
      run(FRAME + 5);

      // Randomized enables, modes and occasional resets.
      for (int i = 0; i < 400; i++) begin
         gen_en   = ($urandom_range(0, 7) != 0);
         gen_mode = 2'($urandom_range(0, 3));
         rst_n    = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_n  = 1'b1;
      gen_en = 1'b0;
      run(FRAME + 2);

      // One-cycle reset mid-ACTIVE, then a restart that behaves like the first frame.
      gen_mode = 2'd0;
      gen_en   = 1'b1;
      step();
      run(49);
      rst_n = 1'b0;
      step();
      check("rst_vsync", {31'd0, cmos_vsync}, 0);
      check("rst_href", {31'd0, cmos_href}, 0);
      check("rst_data", {24'd0, cmos_data}, 0);
      check("rst_done", {31'd0, frame_done}, 0);
      check("rst_cnt", {16'd0, frame_cnt}, 0);
      rst_n = 1'b1;
      e0 = e + 1;
      first_hr = -1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (first_hr < 0 && cmos_href) first_hr = e - e0;
         if (e - e0 == 5) gen_en = 1'b0;
      end
      check("restart_href_ofs", first_hr, FIRST_HREF);
      run(FRAME);
      check("restart_cnt", {16'd0, frame_cnt}, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
